// File: rtl/writeback.sv
// Writeback stage: MEM/WB pipeline register, result select, register-file write port and halt sequencing.
// Optional retired-instruction counter is built only when WB_PERF_CNT_EN is defined.
module writeback #(
  parameter int DATA_W   = 16,
  parameter int LINK_REG = 7,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [15:0]       instr_in,
  input  logic [DATA_W-1:0] aluResult_in,
  input  logic [DATA_W-1:0] memData_in,
  input  logic [DATA_W-1:0] pcPlus2_in,
  input  logic [1:0]        regDestination_in,
  input  logic              mem_to_reg_in,
  input  logic              link_in,
  input  logic              regWrite_in,
  input  logic              halt_in,
  output logic [DATA_W-1:0] writeData,
  output logic [2:0]        regsel,
  output logic              regWrite,
  output logic              wb_valid,
  output logic              halt,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [2:0] LINK_SEL = 3'(LINK_REG);

  state_t            state;
  logic              valid_r;
  logic              regwrite_r;
  logic              halt_r;
  logic              mem_to_reg_r;
  logic              link_r;
  logic [1:0]        dest_r;
  logic [10:2]       instr_r;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] mem_r;
  logic [DATA_W-1:0] pc2_r;

  // Only the three destination fields of the instruction word are ever used.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr_in[15:11], instr_in[1:0]};

  // A flush also counts as a reload: the slot is replaced by a bubble.
  logic reload;
  assign reload = flush | ~stall;

  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the same pre-edge values; blocking would chain updates in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      valid_r      <= 1'b0;
      regwrite_r   <= 1'b0;
      halt_r       <= 1'b0;
      mem_to_reg_r <= 1'b0;
      link_r       <= 1'b0;
      dest_r       <= '0;
      instr_r      <= '0;
      alu_r        <= '0;
      mem_r        <= '0;
      pc2_r        <= '0;
    end else if (state == RUN) begin
      // The HALT retires on the edge after it reaches WB, stalled or not.
      if (valid_r && halt_r) state <= HALTED;

      if (flush) begin
        valid_r      <= 1'b0;
        regwrite_r   <= 1'b0;
        halt_r       <= 1'b0;
        mem_to_reg_r <= 1'b0;
        link_r       <= 1'b0;
      end else if (!stall) begin
        valid_r      <= valid_in;
        regwrite_r   <= regWrite_in;
        halt_r       <= halt_in;
        mem_to_reg_r <= mem_to_reg_in;
        link_r       <= link_in;
        dest_r       <= regDestination_in;
        instr_r      <= instr_in[10:2];
        alu_r        <= aluResult_in;
        mem_r        <= memData_in;
        pc2_r        <= pcPlus2_in;
      end
    end
  end

  // NOTE: each always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    writeData = alu_r;
    if (link_r)            writeData = pc2_r;
    else if (mem_to_reg_r) writeData = mem_r;
  end

  always_comb begin
    regsel = instr_r[4:2];
    case (dest_r)
      2'b00:   regsel = instr_r[4:2];
      2'b01:   regsel = instr_r[7:5];
      2'b10:   regsel = instr_r[10:8];
      default: regsel = LINK_SEL;
    endcase
  end

  assign regWrite = valid_r & regwrite_r & ~halt_r & (state == RUN);
  assign wb_valid = valid_r & (state == RUN);
  assign halt     = (state == HALTED) | (valid_r & halt_r);

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (state == RUN && valid_r && reload) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign instr_count = cnt_r;
`else
  logic unused_reload;
  assign unused_reload = reload;
  assign instr_count   = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: vector table for single-cycle behaviour plus
// hand sequences for halt, asynchronous reset and the retired-instruction counter.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid_in;
  logic [15:0] instr_in, aluResult_in, memData_in, pcPlus2_in;
  logic [1:0]  regDestination_in;
  logic        mem_to_reg_in, link_in, regWrite_in, halt_in;
  logic [15:0] writeData;
  logic [2:0]  regsel;
  logic        regWrite, wb_valid, halt;
  logic [15:0] instr_count;

  int n_vec  = 0;
  int n_fail = 0;

  writeback dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .valid_in          (valid_in),
    .instr_in          (instr_in),
    .aluResult_in      (aluResult_in),
    .memData_in        (memData_in),
    .pcPlus2_in        (pcPlus2_in),
    .regDestination_in (regDestination_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .link_in           (link_in),
    .regWrite_in       (regWrite_in),
    .halt_in           (halt_in),
    .writeData         (writeData),
    .regsel            (regsel),
    .regWrite          (regWrite),
    .wb_valid          (wb_valid),
    .halt              (halt),
    .instr_count       (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, flush, m2r, link, rw, hlt;
    logic [15:0] instr, alu, mem, pc2;
    logic [1:0]  dest;
    logic [15:0] e_wd;
    logic [2:0]  e_sel;
    logic        e_rw, e_wbv, e_halt, chk_data;
  } vec_t;

  function automatic vec_t mk(
    logic valid, logic [15:0] instr, logic [15:0] alu, logic [15:0] mem,
    logic [15:0] pc2, logic [1:0] dest, logic m2r, logic link, logic rw,
    logic hlt, logic stl, logic fl,
    logic [15:0] e_wd, logic [2:0] e_sel, logic e_rw, logic e_wbv,
    logic e_halt, logic chk_data);
    vec_t v;
    v.valid = valid; v.instr = instr; v.alu = alu; v.mem = mem; v.pc2 = pc2;
    v.dest = dest; v.m2r = m2r; v.link = link; v.rw = rw; v.hlt = hlt;
    v.stall = stl; v.flush = fl;
    v.e_wd = e_wd; v.e_sel = e_sel; v.e_rw = e_rw; v.e_wbv = e_wbv;
    v.e_halt = e_halt; v.chk_data = chk_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_in = v.valid; instr_in = v.instr; aluResult_in = v.alu;
    memData_in = v.mem; pcPlus2_in = v.pc2; regDestination_in = v.dest;
    mem_to_reg_in = v.m2r; link_in = v.link; regWrite_in = v.rw;
    halt_in = v.hlt; stall = v.stall; flush = v.flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic e_rw, input logic e_wbv, input logic e_halt);
    check({tag, ".regWrite"}, 32'(regWrite), 32'(e_rw));
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(e_wbv));
    check({tag, ".halt"},     32'(halt),     32'(e_halt));
  endtask

  vec_t vecs[14];
  vec_t idle;

  initial begin
    //            valid instr     alu       mem       pc2      dst m2r lnk rw hlt stl fl | wd       sel rw wbv hlt chk
    vecs[0]  = mk(1, 16'hD8A4, 16'hBEEF, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 0, 0, 16'hBEEF, 3'd1, 1, 1, 0, 1);
    vecs[1]  = mk(1, 16'h00C0, 16'h1111, 16'h00AA, 16'h0000, 2'd1, 1, 0, 1, 0, 0, 0, 16'h00AA, 3'd6, 1, 1, 0, 1);
    vecs[2]  = mk(1, 16'h0000, 16'h2222, 16'h5555, 16'h0042, 2'd3, 1, 1, 1, 0, 0, 0, 16'h0042, 3'd7, 1, 1, 0, 1);
    vecs[3]  = mk(1, 16'h0500, 16'hA5A5, 16'h0000, 16'h0000, 2'd2, 0, 0, 1, 0, 0, 0, 16'hA5A5, 3'd5, 1, 1, 0, 1);
    vecs[4]  = mk(0, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 0, 0, 16'h7777, 3'd0, 0, 0, 0, 1);
    vecs[5]  = mk(1, 16'h001C, 16'h0101, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0, 0, 0, 16'h0101, 3'd7, 0, 1, 0, 1);
    vecs[6]  = mk(1, 16'h0000, 16'h3333, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 0, 0, 16'h3333, 3'd0, 1, 1, 0, 1);
    vecs[7]  = mk(1, 16'hFFFF, 16'h4444, 16'h9999, 16'h8888, 2'd1, 1, 0, 1, 0, 1, 0, 16'h3333, 3'd0, 1, 1, 0, 1);
    vecs[8]  = mk(0, 16'h1234, 16'h5555, 16'h0000, 16'h0000, 2'd2, 0, 0, 0, 0, 1, 0, 16'h3333, 3'd0, 1, 1, 0, 1);
    vecs[9]  = mk(1, 16'h0000, 16'h0000, 16'h0000, 16'h6666, 2'd3, 0, 1, 1, 1, 1, 0, 16'h3333, 3'd0, 1, 1, 0, 1);
    vecs[10] = mk(1, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 1, 1, 16'h0000, 3'd0, 0, 0, 0, 0);
    vecs[11] = mk(1, 16'h0008, 16'hABCD, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 0, 0, 16'hABCD, 3'd2, 1, 1, 0, 1);
    vecs[12] = mk(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 1, 0, 1, 16'h0000, 3'd0, 0, 0, 0, 0);
    vecs[13] = mk(1, 16'h0400, 16'h0F0F, 16'h0000, 16'h0000, 2'd2, 0, 0, 1, 0, 0, 0, 16'h0F0F, 3'd4, 1, 1, 0, 1);
    idle     = mk(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'd0, 0, 0, 0, 0);

    // Reset state
    rst = 1'b0;
    drive(idle);
    #12;
    check("rst.writeData", 32'(writeData), 32'h0);
    check("rst.regsel", 32'(regsel), 32'h0);
    check_ctl("rst", 1'b0, 1'b0, 1'b0);
    check("rst.instr_count", 32'(instr_count), 32'h0);
    rst = 1'b1;

    // Table-driven single-cycle behaviour
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      tick();
      check_ctl($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wbv, vecs[i].e_halt);
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d.writeData", i), 32'(writeData), 32'(vecs[i].e_wd));
        check($sformatf("vec%0d.regsel", i), 32'(regsel), 32'(vecs[i].e_sel));
      end
    end

    // HALT followed by an ALU write to R2: halt from the HALT's WB cycle on, no writes
    drive(mk(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 1, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0));
    tick();
    check_ctl("halt_wb", 1'b0, 1'b1, 1'b1);
    drive(mk(1, 16'h0008, 16'h2222, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0));
    tick();
    check_ctl("halted0", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 16'h0008, 16'(16'h2000 + i), 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0,
               1'(i == 1), 1'(i == 2), 16'h0, 3'd0, 0, 0, 0, 0));
      tick();
      check_ctl($sformatf("halted%0d", i + 1), 1'b0, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-stream discards the instruction in WB
    drive(idle);
    rst = 1'b0;
    #3;
    check_ctl("halt_cleared", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(mk(1, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0));
    tick();
    check("alu1234.writeData", 32'(writeData), 32'h1234);
    check_ctl("alu1234", 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst.writeData", 32'(writeData), 32'h0);
    check("midrst.regsel", 32'(regsel), 32'h0);
    check_ctl("midrst", 1'b0, 1'b0, 1'b0);
    drive(idle);
    #4;
    rst = 1'b1;

    // Counter: 5 valid instructions, 2 bubbles, 1 stall cycle, then HALT
    drive(mk(1, 16'h0, 16'h1, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(mk(1, 16'h0, 16'h2, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(idle); tick();
    drive(mk(1, 16'h0, 16'h3, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(idle); tick();
    drive(mk(1, 16'h0, 16'h4, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(mk(1, 16'h0, 16'h9, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 1, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(mk(1, 16'h0, 16'h5, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(mk(1, 16'h0, 16'h0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 1, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick();
    drive(idle); tick();
    check("cnt.halt", 32'(halt), 32'h1);
`ifdef WB_PERF_CNT_EN
    check("cnt.after_halt", 32'(instr_count), 32'd6);
    drive(mk(1, 16'h0, 16'h7, 16'h0, 16'h0, 2'd0, 0, 0, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 0)); tick(); tick();
    check("cnt.frozen", 32'(instr_count), 32'd6);
`else
    check("cnt.tied_zero", 32'(instr_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
